// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus and decodes each digit back to its hex value.
// Uses per-digit stability filtering and valid/bad flags.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [6:0]                                        seg_in,
    input  logic [NUM_DIGITS-1:0]                             dig_sel,
    output logic [4*NUM_DIGITS-1:0]                           digits,
    output logic [NUM_DIGITS-1:0]                             digit_valid,
    output logic [NUM_DIGITS-1:0]                             bad_pattern,
    output logic                                              sel_error,
    output logic                                              update,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] update_idx
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CntW = $clog2(STABLE_CNT + 1);

    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] sel_s1_q, sel_s2_q;
    logic [DivW-1:0]       div_q;
    logic [6:0]            cand_q [NUM_DIGITS];
    logic [CntW-1:0]       cnt_q  [NUM_DIGITS];

    logic            tick, sel_one_hot, sel_multi, match, commit;
    logic [IdxW-1:0] sel_idx;
    logic [6:0]      cur_cand;
    logic [CntW-1:0] cur_cnt, cnt_next;
    logic [4:0]      dec;

    // Returns {legal, code}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h10;
            7'h06: return 5'h11;
            7'h5B: return 5'h12;
            7'h4F: return 5'h13;
            7'h66: return 5'h14;
            7'h6D: return 5'h15;
            7'h7D: return 5'h16;
            7'h07: return 5'h17;
            7'h7F: return 5'h18;
            7'h6F: return 5'h19;
            7'h77: return 5'h1A;
            7'h7C: return 5'h1B;
            7'h39: return 5'h1C;
            7'h5E: return 5'h1D;
            7'h79: return 5'h1E;
            7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        tick        = (div_q == DivW'(SAMPLE_DIV - 1));
        sel_one_hot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - 1'b1)) == '0);
        sel_multi   = (sel_s2_q != '0) && !sel_one_hot;
        sel_idx     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_s2_q[k]) sel_idx = IdxW'(k);
        end
        cur_cand = cand_q[sel_idx];
        cur_cnt  = cnt_q[sel_idx];
        match    = (seg_s2_q == cur_cand);
        if (!match) begin
            cnt_next = CntW'(1);
        end else if (cur_cnt == CntW'(STABLE_CNT)) begin
            cnt_next = cur_cnt;
        end else begin
            cnt_next = cur_cnt + 1'b1;
        end
        // Commit only on the transition into STABLE_CNT, never while saturated.
        commit = tick && sel_one_hot &&
                 (match ? (cur_cnt == CntW'(STABLE_CNT - 1)) : (STABLE_CNT == 1));
        dec    = decode(seg_s2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            div_q       <= '0;
            digits      <= '0;
            digit_valid <= '0;
            bad_pattern <= '0;
            sel_error   <= 1'b0;
            update      <= 1'b0;
            update_idx  <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                cand_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            sel_s1_q   <= dig_sel;
            sel_s2_q   <= sel_s1_q;
            div_q      <= tick ? '0 : div_q + 1'b1;
            sel_error  <= tick && sel_multi;
            update     <= commit;
            update_idx <= commit ? sel_idx : '0;
            if (tick && sel_one_hot) begin
                cand_q[sel_idx] <= seg_s2_q;
                cnt_q[sel_idx]  <= cnt_next;
            end
            if (commit) begin
                if (dec[4]) begin
                    digits[{sel_idx, 2'b00} +: 4] <= dec[3:0];
                    digit_valid[sel_idx]          <= 1'b1;
                    bad_pattern[sel_idx]          <= 1'b0;
                end else begin
                    digit_valid[sel_idx] <= 1'b0;
                    bad_pattern[sel_idx] <= (seg_s2_q != 7'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a fast instance (sample every cycle) with a commit scoreboard,
// plus a SAMPLE_DIV=16 instance for divider timing.
module tb_seg7_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] digits;
    logic [3:0]  digit_valid, bad_pattern;
    logic        sel_error, update;
    logic [1:0]  update_idx;

    logic [6:0]  s_seg = '0;
    logic [3:0]  s_sel = '0;
    logic [15:0] s_digits;
    logic [3:0]  s_valid, s_bad;
    logic        s_sel_error, s_update;
    logic [1:0]  s_update_idx;

    seg7_scan_decoder #(.NUM_DIGITS(4), .SAMPLE_DIV(1), .STABLE_CNT(3)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .digits(digits),
        .digit_valid(digit_valid), .bad_pattern(bad_pattern), .sel_error(sel_error),
        .update(update), .update_idx(update_idx)
    );

    seg7_scan_decoder #(.NUM_DIGITS(4), .SAMPLE_DIV(16), .STABLE_CNT(3)) dut_slow (
        .clk(clk), .rst(rst), .seg_in(s_seg), .dig_sel(s_sel), .digits(s_digits),
        .digit_valid(s_valid), .bad_pattern(s_bad), .sel_error(s_sel_error),
        .update(s_update), .update_idx(s_update_idx)
    );

    // kind: 0 = legal code, 1 = blank, 2 = bad pattern
    typedef struct {
        int         idx;
        int         kind;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_update = 0;
    int   n_sel_err = 0;

    // Scoreboard monitor: every update pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (update && sel_error) begin
                bad++;
                $display("FAIL excl: update=%0b sel_error=%0b both set", update, sel_error);
            end
            if (sel_error) n_sel_err++;
            if (update) begin
                n_update++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_update: idx=%0d, none expected", update_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (update_idx !== 2'(e.idx) ||
                        digit_valid[e.idx] !== (e.kind == 0) ||
                        bad_pattern[e.idx] !== (e.kind == 2) ||
                        (e.kind == 0 && digits[4*e.idx +: 4] !== e.code)) begin
                        bad++;
                        $display("FAIL commit: idx=%0d v=%b b=%b d=%h, want idx=%0d kind=%0d code=%h",
                                 update_idx, digit_valid, bad_pattern, digits, e.idx, e.kind,
                                 e.code);
                    end
                end
            end else if (update_idx !== 2'd0) begin
                total++;
                bad++;
                $display("FAIL idx_idle: update_idx=%0d want 0", update_idx);
            end
        end
    end

    task automatic apply(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        seg_in  = '0;
        dig_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({digits, digit_valid, bad_pattern, sel_error, update, update_idx} !== '0) begin
            bad++;
            $display("FAIL reset_init: d=%h v=%b b=%b se=%b u=%b want all 0",
                     digits, digit_valid, bad_pattern, sel_error, update);
        end
        exp_q.push_back('{idx: 1, kind: 0, code: 4'h1});
        apply(7'h06, 4'b0010, 5);
        apply(7'h3F, 4'b0001, 4);
        total++;
        if (digit_valid !== 4'b0010 || digits !== 16'h0010) begin
            bad++;
            $display("FAIL pre_reset: v=%b d=%h want v=0010 d=0010", digit_valid, digits);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({digits, digit_valid, bad_pattern, sel_error, update, update_idx} !== '0) begin
            bad++;
            $display("FAIL reset_mid: d=%h v=%b b=%b want all 0", digits, digit_valid,
                     bad_pattern);
        end
        rst = 1'b0;
        exp_q.push_back('{idx: 0, kind: 0, code: 4'h0});
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (update !== (i == 5)) begin
                bad++;
                $display("FAIL reset_recommit: cycle %0d update=%b want %b", i, update, i == 5);
            end
        end
        total++;
        if (digit_valid !== 4'b0001) begin
            bad++;
            $display("FAIL reset_after: v=%b want 0001", digit_valid);
        end
    endtask

    task automatic test_scan();
        int u0;
        do_reset();
        u0 = n_update;
        exp_q.push_back('{idx: 0, kind: 0, code: 4'h0});
        exp_q.push_back('{idx: 1, kind: 0, code: 4'h1});
        exp_q.push_back('{idx: 2, kind: 0, code: 4'h2});
        exp_q.push_back('{idx: 3, kind: 0, code: 4'h3});
        apply(7'h3F, 4'b0001, 3);
        apply(7'h06, 4'b0010, 3);
        apply(7'h5B, 4'b0100, 3);
        apply(7'h4F, 4'b1000, 3);
        apply(7'h00, 4'b0000, 4);
        total++;
        if (digits !== 16'h3210 || digit_valid !== 4'hF || n_update - u0 != 4 ||
            exp_q.size() != 0) begin
            bad++;
            $display("FAIL scan: d=%h v=%b updates=%0d left=%0d want 3210 1111 4 0",
                     digits, digit_valid, n_update - u0, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int u0;
        u0 = n_update;
        exp_q.push_back('{idx: 2, kind: 0, code: 4'hF});
        apply(7'h79, 4'b0100, 2);
        apply(7'h71, 4'b0100, 3);
        apply(7'h00, 4'b0000, 4);
        total++;
        if (digits[11:8] !== 4'hF || digit_valid[2] !== 1'b1 || n_update - u0 != 1) begin
            bad++;
            $display("FAIL glitch: d2=%h v2=%b updates=%0d want F 1 1",
                     digits[11:8], digit_valid[2], n_update - u0);
        end
    endtask

    task automatic test_illegal();
        exp_q.push_back('{idx: 1, kind: 2, code: 4'h0});
        apply(7'h55, 4'b0010, 3);
        apply(7'h00, 4'b0000, 4);
        total++;
        if (bad_pattern[1] !== 1'b1 || digit_valid[1] !== 1'b0 || digits[7:4] !== 4'h1 ||
            exp_q.size() != 0) begin
            bad++;
            $display("FAIL illegal: b1=%b v1=%b d1=%h want 1 0 1", bad_pattern[1],
                     digit_valid[1], digits[7:4]);
        end
    endtask

    task automatic test_blank_sel();
        logic [23:0] snap;
        int          e0, u0;
        exp_q.push_back('{idx: 3, kind: 1, code: 4'h0});
        apply(7'h00, 4'b1000, 3);
        apply(7'h00, 4'b0000, 4);
        total++;
        if (digit_valid[3] !== 1'b0 || bad_pattern[3] !== 1'b0 || digits[15:12] !== 4'h3) begin
            bad++;
            $display("FAIL blank: v3=%b b3=%b d3=%h want 0 0 3", digit_valid[3],
                     bad_pattern[3], digits[15:12]);
        end
        snap = {digits, digit_valid, bad_pattern};
        e0 = n_sel_err;
        u0 = n_update;
        apply(7'h3F, 4'b0110, 1);
        seg_in  = '0;
        dig_sel = '0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (sel_error !== (i == 2)) begin
                bad++;
                $display("FAIL sel_pulse: cycle %0d sel_error=%b want %b", i, sel_error, i == 2);
            end
        end
        apply(7'h3F, 4'b0000, 6);
        total++;
        if (n_sel_err - e0 != 1 || n_update != u0 || {digits, digit_valid, bad_pattern} !== snap)
        begin
            bad++;
            $display("FAIL sel_state: pulses=%0d updates=%0d state=%h want 1 0 %h",
                     n_sel_err - e0, n_update - u0, {digits, digit_valid, bad_pattern}, snap);
        end
    endtask

    task automatic test_slow_div();
        int c;
        s_seg = 7'h3F;
        s_sel = 4'b0001;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            c = 0;
            for (int i = 1; i <= 200; i++) begin
                @(posedge clk);
                #1;
                if (s_update) begin
                    c = i;
                    break;
                end
            end
            total++;
            if (c != 48 || s_digits[3:0] !== 4'(pass) || s_valid !== 4'b0001) begin
                bad++;
                $display("FAIL slow_commit%0d: cycles=%0d d0=%h v=%b want 48 %0d 0001",
                         pass, c, s_digits[3:0], s_valid, pass);
            end
            s_seg = 7'h06;
        end
        @(posedge clk);
        #1;
        total++;
        if (s_update !== 1'b0 || s_sel_error !== 1'b0) begin
            bad++;
            $display("FAIL slow_pulse: update=%b sel_error=%b want 0 0", s_update, s_sel_error);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_illegal();
        test_blank_sel();
        test_slow_div();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected commits never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
